nand_cmd_seq: RTL and testbench
===============================

NAND_CMD_SEQ -- requirements
Module: nand_cmd_seq

Interface
REQ-001 Parameter T_CS, default 2, sets CE#-to-first-WE# setup in clk0 cycles (legal 1..15).
REQ-002 Parameter T_WP, default 3, sets WE# low time per byte in cycles (1..15).
REQ-003 Parameter T_WH, default 3, sets WE# high time per byte in cycles (1..15).
REQ-004 Parameter T_CH, default 2, sets hold after last byte before CE# release, in cycles (1..15).
REQ-005 clk0  in  1  sole clock; all state changes on its rising edge.
REQ-006 rstn0  in  1  synchronous, active-low reset.
REQ-007 req_valid  in  1  command request.
REQ-008 req_ready  out  1  high only in IDLE; a transfer occurs when req_valid and req_ready are both high.
REQ-009 req_cmd0  in  8  first command byte (CLE cycle).
REQ-010 req_naddr  in  3  address byte count 0..5; values 6..7 are treated as 5.
REQ-011 req_addr  in  40  address bytes, issued [7:0] first, then [15:8], and so on.
REQ-012 req_cmd1_en  in  1  issue second command byte after the address bytes.
REQ-013 req_cmd1  in  8  second command byte.
REQ-014 req_ce  in  3  target chip index into ctrl_cen.
REQ-015 wp_n_in  in  1  write-protect level.
REQ-016 done  out  1  one-cycle completion pulse.
REQ-017 busy  out  1  equals NOT req_ready.
REQ-018 ctrl_cle, ctrl_ale, ctrl_wen, ctrl_wen_sel, ctrl_wrn, ctrl_wpn  out  1 each  PHY control signals.
REQ-019 ctrl_cen  out  8  active-low chip enables.
REQ-020 dq_oe_n  out  1  DQ output enable, active-low.
REQ-021 wr_data_rise, wr_data_fall  out  8 each  PHY write data; both always carry the same byte.

Function
REQ-022 All outputs shall be registered; the ODDR stage in the PHY adds one further cycle on WE#, and no compensation is applied here.
REQ-023 ctrl_wen_sel shall be held at 0 (asynchronous WE# mode), and ctrl_wrn shall be held at 1 (no reads).
REQ-024 ctrl_wpn shall be wp_n_in delayed by one cycle, in every state.
REQ-025 States: IDLE, CS_SETUP, WE_LOW, WE_HIGH, HOLD.
REQ-026 On accept, all request fields shall be latched; later input changes have no effect until the next accept.
REQ-027 Byte list B shall be cmd0, then req_naddr address bytes, then cmd1 if req_cmd1_en is set; byte count is 1 to 7.
REQ-028 CS_SETUP lasts T_CS cycles and starts the cycle after accept.
  - ctrl_cen[req_ce] = 0, all other CE# = 1.
  - cle = ale = 0, wen = 1, dq_oe_n = 1.
REQ-029 WE_LOW lasts T_WP cycles.
  - wen = 0, dq_oe_n = 0, wr_data = current byte.
  - cle = 1 for command bytes; ale = 1 for address bytes.
REQ-030 WE_HIGH lasts T_WH cycles; wen = 1, and cle, ale, wr_data and dq_oe_n are unchanged from WE_LOW.
REQ-031 After WE_HIGH, the FSM shall go to WE_LOW for the next byte, or to HOLD after the last byte.
REQ-032 HOLD lasts T_CH cycles.
  - Selected CE# stays 0.
  - cle = ale = 0, wen = 1, dq_oe_n = 1; wr_data holds the last byte.
REQ-033 After HOLD, the FSM shall enter IDLE.
  - In the first IDLE cycle: done = 1, ctrl_cen = 8'hFF, req_ready = 1.
REQ-034 Latency: done asserts at cycle N+1+T_CS+|B|*(T_WP+T_WH)+T_CH, where N is the accept cycle.
REQ-035 A single 4-bit down-counter shall time all phases; it loads (T-1) on phase entry, and the phase ends when the counter reads 0.
REQ-036 A request presented while req_ready = 0 shall be ignored and shall not be queued.
REQ-037 req_valid high in the same cycle done is high shall be accepted (back-to-back operation); CE# deasserts for at least that one cycle.
REQ-038 In IDLE: cen = 8'hFF, cle = ale = 0, wen = 1, dq_oe_n = 1, and wr_data holds its last value.

Reset
REQ-039 While rstn0 = 0 at a clock edge, the next state shall be as follows.
  - FSM = IDLE, counters = 0.
  - req_ready = 0 during reset, 1 on the first cycle after release.
  - busy = 1 during reset.
  - done = 0, ctrl_cen = 8'hFF, cle = ale = 0, wen = 1, ctrl_wen_sel = 0, ctrl_wrn = 1.
  - ctrl_wpn = 0, dq_oe_n = 1, wr_data = 0.
REQ-040 Reset asserted mid-operation shall abort the operation with no done pulse; all latched request fields are discarded.

Verification
REQ-041 Defaults, cmd0 = 8'hFF, naddr = 0, cmd1 off, ce = 3, accept at N:
  - cen = 8'hF7 over N+1..N+10.
  - wen = 0 over N+3..N+5 with cle = 1 and data FF.
  - done pulses at N+11.
REQ-042 Defaults, cmd0 = 00, naddr = 5, addr = 40'h0504030201, cmd1 = 30 enabled:
  - ALE bytes appear in order 01, 02, 03, 04, 05.
  - cmd1 = 30 is issued with CLE.
  - done at N+1+2+7*6+2 = N+47.
REQ-043 naddr = 7 shall produce exactly 5 ALE pulses.
REQ-044 req_valid held high continuously: second accept in the done cycle, new CS_SETUP on the next cycle, and requests during busy are ignored.
REQ-045 rstn0 low for one cycle during the 3rd WE_LOW: next cycle all outputs at reset values, no done pulse, and req_ready = 1 on the cycle after release.
REQ-046 T_WP = T_WH = 1: WE# toggles every cycle and the latency formula still holds.

Source files
------------

// File: rtl/nand_cmd_seq.sv
// NAND command/address write sequencer: drives CE#/CLE/ALE/WE# and write data
// for cmd0, up to five address bytes and an optional cmd1, all timed by one down-counter.
//
// state      | meaning
// S_IDLE     | waiting for a request, CE# released
// S_CS_SETUP | CE# low, before the first WE# pulse (T_CS cycles)
// S_WE_LOW   | WE# low, byte on DQ (T_WP cycles)
// S_WE_HIGH  | WE# high, byte and CLE/ALE held (T_WH cycles)
// S_HOLD     | CE# still low after the last byte (T_CH cycles)
module nand_cmd_seq #(
    parameter int T_CS = 2,
    parameter int T_WP = 3,
    parameter int T_WH = 3,
    parameter int T_CH = 2
) (
    input  logic        clk0,
    input  logic        rstn0,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_cmd0,
    input  logic [2:0]  req_naddr,
    input  logic [39:0] req_addr,
    input  logic        req_cmd1_en,
    input  logic [7:0]  req_cmd1,
    input  logic [2:0]  req_ce,
    input  logic        wp_n_in,
    output logic        done,
    output logic        busy,
    output logic        ctrl_cle,
    output logic        ctrl_ale,
    output logic        ctrl_wen,
    output logic        ctrl_wen_sel,
    output logic        ctrl_wrn,
    output logic        ctrl_wpn,
    output logic [7:0]  ctrl_cen,
    output logic        dq_oe_n,
    output logic [7:0]  wr_data_rise,
    output logic [7:0]  wr_data_fall
);

    localparam logic [3:0] LD_CS = 4'(T_CS - 1);
    localparam logic [3:0] LD_WP = 4'(T_WP - 1);
    localparam logic [3:0] LD_WH = 4'(T_WH - 1);
    localparam logic [3:0] LD_CH = 4'(T_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CS_SETUP,
        S_WE_LOW,
        S_WE_HIGH,
        S_HOLD
    } state_t;

    state_t      state, state_nx;
    logic [3:0]  tmr, tmr_nx;
    logic [2:0]  idx, idx_nx;

    logic [7:0]  cmd0_q, cmd1_q;
    logic [2:0]  naddr_q, ce_q;
    logic [39:0] addr_q;
    logic        cmd1_en_q;

    logic        accept;
    logic        last_byte;
    logic [2:0]  nbytes_m1;

    logic [7:0]  byte_nx;
    logic        is_cmd_nx;
    logic [2:0]  ce_sel;
    logic [7:0]  cen_nx;
    logic        cle_nx, ale_nx, wen_nx, oe_nx, done_nx;
    logic [7:0]  data_nx;
    logic [7:0]  wr_data;

    assign accept    = req_valid && req_ready;
    assign nbytes_m1 = naddr_q + {2'b00, cmd1_en_q};
    assign last_byte = (idx == nbytes_m1);

    assign busy         = ~req_ready;
    assign ctrl_wen_sel = 1'b0;
    assign ctrl_wrn     = 1'b1;
    assign wr_data_rise = wr_data;
    assign wr_data_fall = wr_data;

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge clk0) begin
        if (!rstn0) begin
            state     <= S_IDLE;
            tmr       <= 4'd0;
            idx       <= 3'd0;
            cmd0_q    <= 8'h00;
            cmd1_q    <= 8'h00;
            naddr_q   <= 3'd0;
            ce_q      <= 3'd0;
            addr_q    <= 40'h0;
            cmd1_en_q <= 1'b0;
            req_ready <= 1'b0;
            done      <= 1'b0;
            ctrl_cen  <= 8'hFF;
            ctrl_cle  <= 1'b0;
            ctrl_ale  <= 1'b0;
            ctrl_wen  <= 1'b1;
            ctrl_wpn  <= 1'b0;
            dq_oe_n   <= 1'b1;
            wr_data   <= 8'h00;
        end else begin
            state     <= state_nx;
            tmr       <= tmr_nx;
            idx       <= idx_nx;
            if (accept) begin
                cmd0_q    <= req_cmd0;
                cmd1_q    <= req_cmd1;
                naddr_q   <= (req_naddr > 3'd5) ? 3'd5 : req_naddr;
                ce_q      <= req_ce;
                addr_q    <= req_addr;
                cmd1_en_q <= req_cmd1_en;
            end
            req_ready <= (state_nx == S_IDLE);
            done      <= done_nx;
            ctrl_cen  <= cen_nx;
            ctrl_cle  <= cle_nx;
            ctrl_ale  <= ale_nx;
            ctrl_wen  <= wen_nx;
            ctrl_wpn  <= wp_n_in;
            dq_oe_n   <= oe_nx;
            wr_data   <= data_nx;
        end
    end

    always_comb begin
        state_nx = state;
        tmr_nx   = tmr;
        idx_nx   = idx;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nx = S_CS_SETUP;
                    tmr_nx   = LD_CS;
                    idx_nx   = 3'd0;
                end
            end
            S_CS_SETUP: begin
                if (tmr == 4'd0) begin
                    state_nx = S_WE_LOW;
                    tmr_nx   = LD_WP;
                end else begin
                    tmr_nx = tmr - 4'd1;
                end
            end
            S_WE_LOW: begin
                if (tmr == 4'd0) begin
                    state_nx = S_WE_HIGH;
                    tmr_nx   = LD_WH;
                end else begin
                    tmr_nx = tmr - 4'd1;
                end
            end
            S_WE_HIGH: begin
                if (tmr == 4'd0) begin
                    if (last_byte) begin
                        state_nx = S_HOLD;
                        tmr_nx   = LD_CH;
                    end else begin
                        state_nx = S_WE_LOW;
                        tmr_nx   = LD_WP;
                        idx_nx   = idx + 3'd1;
                    end
                end else begin
                    tmr_nx = tmr - 4'd1;
                end
            end
            S_HOLD: begin
                if (tmr == 4'd0) begin
                    state_nx = S_IDLE;
                    tmr_nx   = 4'd0;
                end else begin
                    tmr_nx = tmr - 4'd1;
                end
            end
            default: begin
                state_nx = S_IDLE;
                tmr_nx   = 4'd0;
                idx_nx   = 3'd0;
            end
        endcase
    end

    always_comb begin
        byte_nx   = cmd0_q;
        is_cmd_nx = 1'b1;
        if (idx_nx != 3'd0) begin
            if (idx_nx > naddr_q) begin
                byte_nx = cmd1_q;
            end else begin
                is_cmd_nx = 1'b0;
                case (idx_nx)
                    3'd1:    byte_nx = addr_q[7:0];
                    3'd2:    byte_nx = addr_q[15:8];
                    3'd3:    byte_nx = addr_q[23:16];
                    3'd4:    byte_nx = addr_q[31:24];
                    3'd5:    byte_nx = addr_q[39:32];
                    default: byte_nx = 8'h00;
                endcase
            end
        end

        // On the accept cycle the latched CE index is not yet valid.
        ce_sel  = accept ? req_ce : ce_q;
        cen_nx  = 8'hFF;
        cle_nx  = 1'b0;
        ale_nx  = 1'b0;
        wen_nx  = 1'b1;
        oe_nx   = 1'b1;
        data_nx = wr_data;
        case (state_nx)
            S_CS_SETUP, S_HOLD: begin
                cen_nx = ~(8'h01 << ce_sel);
            end
            S_WE_LOW, S_WE_HIGH: begin
                cen_nx  = ~(8'h01 << ce_sel);
                cle_nx  = is_cmd_nx;
                ale_nx  = ~is_cmd_nx;
                wen_nx  = (state_nx == S_WE_HIGH);
                oe_nx   = 1'b0;
                data_nx = byte_nx;
            end
            default: ;
        endcase
        done_nx = (state == S_HOLD) && (state_nx == S_IDLE);
    end

endmodule

// File: tb/tb_nand_cmd_seq.sv
// Bench for nand_cmd_seq: two instances (default timing and T_WP=T_WH=1) driven in parallel,
// each compared every cycle against an expected waveform expanded from the request.
module tb_nand_cmd_seq;

    localparam int CS0 = 2, WP0 = 3, WH0 = 3, CH0 = 2;
    localparam int CS1 = 4, WP1 = 1, WH1 = 1, CH1 = 5;

    logic        clk0 = 1'b0;
    logic        rstn0;
    logic        req_valid;
    logic [7:0]  req_cmd0;
    logic [2:0]  req_naddr;
    logic [39:0] req_addr;
    logic        req_cmd1_en;
    logic [7:0]  req_cmd1;
    logic [2:0]  req_ce;
    logic        wp_n_in;

    logic       ready_o[2], done_o[2], busy_o[2], cle_o[2], ale_o[2], wen_o[2];
    logic       wsel_o[2], wrn_o[2], wpn_o[2], oe_o[2];
    logic [7:0] cen_o[2], rise_o[2], fall_o[2];

    always #5 clk0 = ~clk0;

    nand_cmd_seq #(.T_CS(CS0), .T_WP(WP0), .T_WH(WH0), .T_CH(CH0)) u_dut0 (
        .clk0(clk0), .rstn0(rstn0), .req_valid(req_valid), .req_ready(ready_o[0]),
        .req_cmd0(req_cmd0), .req_naddr(req_naddr), .req_addr(req_addr),
        .req_cmd1_en(req_cmd1_en), .req_cmd1(req_cmd1), .req_ce(req_ce), .wp_n_in(wp_n_in),
        .done(done_o[0]), .busy(busy_o[0]), .ctrl_cle(cle_o[0]), .ctrl_ale(ale_o[0]),
        .ctrl_wen(wen_o[0]), .ctrl_wen_sel(wsel_o[0]), .ctrl_wrn(wrn_o[0]), .ctrl_wpn(wpn_o[0]),
        .ctrl_cen(cen_o[0]), .dq_oe_n(oe_o[0]), .wr_data_rise(rise_o[0]), .wr_data_fall(fall_o[0])
    );

    nand_cmd_seq #(.T_CS(CS1), .T_WP(WP1), .T_WH(WH1), .T_CH(CH1)) u_dut1 (
        .clk0(clk0), .rstn0(rstn0), .req_valid(req_valid), .req_ready(ready_o[1]),
        .req_cmd0(req_cmd0), .req_naddr(req_naddr), .req_addr(req_addr),
        .req_cmd1_en(req_cmd1_en), .req_cmd1(req_cmd1), .req_ce(req_ce), .wp_n_in(wp_n_in),
        .done(done_o[1]), .busy(busy_o[1]), .ctrl_cle(cle_o[1]), .ctrl_ale(ale_o[1]),
        .ctrl_wen(wen_o[1]), .ctrl_wen_sel(wsel_o[1]), .ctrl_wrn(wrn_o[1]), .ctrl_wpn(wpn_o[1]),
        .ctrl_cen(cen_o[1]), .dq_oe_n(oe_o[1]), .wr_data_rise(rise_o[1]), .wr_data_fall(fall_o[1])
    );

    typedef struct packed {
        logic [7:0] cen;
        logic       cle;
        logic       ale;
        logic       wen;
        logic       oe;
        logic       done;
        logic       rdy;
        logic [7:0] data;
    } exp_t;

    exp_t       q0[$], q1[$];
    exp_t       cur[2];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    bit         rst_next[2];
    bit         pend[2];
    int         acc_cyc[2];
    int         lat_exp[2];
    logic [7:0] last_data[2];
    logic       wpn_exp;
    int         wl_cnt0;
    logic       prev_exp_wen0;
    logic       prev_wen0;
    logic [7:0] ale_log[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, want);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] cen, input logic cle, input logic ale,
                                input logic wen, input logic oe, input logic dn,
                                input logic rdy, input logic [7:0] data);
        exp_t e;
        e.cen = cen; e.cle = cle; e.ale = ale; e.wen = wen;
        e.oe = oe; e.done = dn; e.rdy = rdy; e.data = data;
        return e;
    endfunction

    function automatic int p_cs(input int k); return (k == 0) ? CS0 : CS1; endfunction
    function automatic int p_wp(input int k); return (k == 0) ? WP0 : WP1; endfunction
    function automatic int p_wh(input int k); return (k == 0) ? WH0 : WH1; endfunction
    function automatic int p_ch(input int k); return (k == 0) ? CH0 : CH1; endfunction

    task automatic push_exp(input int k, input exp_t e);
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Expand the request into its cycle-by-cycle waveform, starting the cycle after accept.
    task automatic build(input int k);
        logic [7:0] b[$];
        bit         c[$];
        int         n;
        logic [7:0] cen, lastb;
        n = (req_naddr > 3'd5) ? 5 : int'(req_naddr);
        b.push_back(req_cmd0); c.push_back(1'b1);
        for (int i = 0; i < n; i++) begin
            b.push_back(req_addr[8*i +: 8]);
            c.push_back(1'b0);
        end
        if (req_cmd1_en) begin
            b.push_back(req_cmd1);
            c.push_back(1'b1);
        end
        cen   = ~(8'h01 << req_ce);
        lastb = b[b.size()-1];
        for (int t = 0; t < p_cs(k); t++)
            push_exp(k, mk(cen, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, last_data[k]));
        for (int j = 0; j < b.size(); j++) begin
            for (int t = 0; t < p_wp(k); t++)
                push_exp(k, mk(cen, c[j], !c[j], 1'b0, 1'b0, 1'b0, 1'b0, b[j]));
            for (int t = 0; t < p_wh(k); t++)
                push_exp(k, mk(cen, c[j], !c[j], 1'b1, 1'b0, 1'b0, 1'b0, b[j]));
        end
        for (int t = 0; t < p_ch(k); t++)
            push_exp(k, mk(cen, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, lastb));
        push_exp(k, mk(8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, lastb));
        last_data[k] = lastb;
        pend[k]      = 1'b1;
        acc_cyc[k]   = cyc;
        lat_exp[k]   = 1 + p_cs(k) + b.size() * (p_wp(k) + p_wh(k)) + p_ch(k);
    endtask

    // Advance one clock with the inputs as currently driven, then compare both instances.
    task automatic tick();
        for (int k = 0; k < 2; k++) begin
            if (!rstn0) begin
                rst_next[k] = 1'b1;
                pend[k]     = 1'b0;
                if (k == 0) q0.delete();
                else        q1.delete();
            end else if (req_valid && cur[k].rdy) begin
                build(k);
            end
        end
        wpn_exp = rstn0 ? wp_n_in : 1'b0;
        @(posedge clk0);
        #1;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (rst_next[k]) begin
                cur[k]       = mk(8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
                last_data[k] = 8'h00;
                rst_next[k]  = 1'b0;
            end else if (k == 0 && q0.size() > 0) begin
                cur[k] = q0.pop_front();
            end else if (k == 1 && q1.size() > 0) begin
                cur[k] = q1.pop_front();
            end else begin
                cur[k] = mk(8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, last_data[k]);
            end
            check($sformatf("cen%0d", k), cen_o[k], cur[k].cen);
            check($sformatf("ctl%0d", k),
                  {cle_o[k], ale_o[k], wen_o[k], oe_o[k], done_o[k], ready_o[k], busy_o[k]},
                  {cur[k].cle, cur[k].ale, cur[k].wen, cur[k].oe, cur[k].done, cur[k].rdy, !cur[k].rdy});
            check($sformatf("data%0d", k), {rise_o[k], fall_o[k]}, {cur[k].data, cur[k].data});
            check($sformatf("static%0d", k), {wsel_o[k], wrn_o[k], wpn_o[k]}, {1'b0, 1'b1, wpn_exp});
            if (done_o[k] && pend[k]) begin
                check($sformatf("latency%0d", k), cyc - acc_cyc[k], lat_exp[k]);
                pend[k] = 1'b0;
            end
        end
        if (ale_o[0] && !wen_o[0] && prev_wen0) ale_log.push_back(rise_o[0]);
        prev_wen0 = wen_o[0];
        if (!cur[0].wen && prev_exp_wen0) wl_cnt0++;
        prev_exp_wen0 = cur[0].wen;
        wp_n_in = 1'($urandom);
    endtask

    task automatic rand_fields();
        req_cmd0    = 8'($urandom);
        req_naddr   = 3'($urandom);
        req_addr    = {8'($urandom), 32'($urandom)};
        req_cmd1_en = 1'($urandom);
        req_cmd1    = 8'($urandom);
        req_ce      = 3'($urandom);
    endtask

    task automatic drain();
        int i;
        i = 0;
        while ((q0.size() > 0 || q1.size() > 0) && i < 400) begin
            tick();
            i++;
        end
        check("drain_timeout", (i < 400), 1);
    endtask

    task automatic run_op(input logic [7:0] c0, input logic [2:0] na, input logic [39:0] ad,
                          input logic c1e, input logic [7:0] c1, input logic [2:0] ce,
                          input int rst_wl);
        int i;
        bit rst_done;
        rst_done = 1'b0;
        i = 0;
        while (!(cur[0].rdy && cur[1].rdy) && i < 400) begin
            tick();
            i++;
        end
        check("ready_wait", {ready_o[0], ready_o[1]}, 2'b11);
        req_cmd0 = c0; req_naddr = na; req_addr = ad;
        req_cmd1_en = c1e; req_cmd1 = c1; req_ce = ce;
        req_valid = 1'b1;
        ale_log.delete();
        wl_cnt0 = 0;
        tick();
        req_valid = 1'b0;
        rand_fields();
        i = 0;
        while ((q0.size() > 0 || q1.size() > 0) && i < 400) begin
            if (rst_wl > 0 && !rst_done && wl_cnt0 == rst_wl && !cur[0].wen) begin
                rstn0    = 1'b0;
                rst_done = 1'b1;
            end
            tick();
            rstn0 = 1'b1;
            i++;
        end
        check("op_timeout", (i < 400), 1);
    endtask

    initial begin
        rstn0 = 1'b0;
        req_valid = 1'b0;
        req_cmd0 = 8'h00; req_naddr = 3'd0; req_addr = 40'h0;
        req_cmd1_en = 1'b0; req_cmd1 = 8'h00; req_ce = 3'd0;
        wp_n_in = 1'b1;
        prev_wen0 = 1'b1;
        prev_exp_wen0 = 1'b1;
        wl_cnt0 = 0;
        for (int k = 0; k < 2; k++) begin
            cur[k]       = mk(8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
            rst_next[k]  = 1'b0;
            pend[k]      = 1'b0;
            acc_cyc[k]   = 0;
            lat_exp[k]   = 0;
            last_data[k] = 8'h00;
        end
        repeat (3) tick();
        rstn0 = 1'b1;

        run_op(8'hFF, 3'd0, 40'h0, 1'b0, 8'h00, 3'd3, 0);

        run_op(8'h00, 3'd5, 40'h0504030201, 1'b1, 8'h30, 3'd2, 0);
        check("ale_cnt_b", ale_log.size(), 5);
        for (int i = 0; i < ale_log.size() && i < 5; i++)
            check("ale_order", ale_log[i], i + 1);

        run_op(8'h5A, 3'd7, 40'hA1B2C3D4E5, 1'b0, 8'h00, 3'd1, 0);
        check("ale_cnt_7", ale_log.size(), 5);

        req_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            rand_fields();
            tick();
        end
        req_valid = 1'b0;
        drain();

        run_op(8'h80, 3'd3, 40'h00_0033_2211, 1'b1, 8'h10, 3'd5, 3);

        for (int i = 0; i < 2500; i++) begin
            rand_fields();
            req_valid = ($urandom_range(0, 2) == 0);
            rstn0     = ($urandom_range(0, 299) != 0);
            tick();
        end
        rstn0 = 1'b1;
        req_valid = 1'b0;
        drain();
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
